vote_collector: RTL
===================

Name: vote_collector

Overview:
- Sequential front end for the team's 5-input combinational majority voter; sits directly upstream of it.
- Collects one ballot per voter (IDs 0-4) over a valid/ready handshake and assembles the 5-bit vote word that drives the voter.
- Samples the voter's majority output back as the final decision and reports it with a yes-count.
- Missing ballots default to 0 after a timeout.

Parameters:
- TIMEOUT, 64: COLLECT-state cycles allowed before forced evaluation; legal range 1..65535.
- NUM_VOTERS, 5: fixed at 5, matching the voter width; any other value is illegal.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begins a new election; honoured only in IDLE.
- ballot_valid  in  1  ballot present this cycle.
- ballot_ready  out  1  collector accepts ballots; high only in COLLECT.
- voter_id  in  3  voter index; legal values 0..4.
- ballot  in  1  vote value, 1 = yes.
- vote  out  5  assembled vote word to the majority voter; bit i = voter i.
- majority_in  in  1  majority result returned by the voter.
- result_valid  out  1  decision, yes_count and timed_out are valid.
- result_ack  in  1  consumer acknowledges the result.
- decision  out  1  registered majority verdict.
- yes_count  out  3  number of 1 bits in vote, 0..5.
- timed_out  out  1  election closed by timeout.
- dup_err  out  1  sticky: a repeat ballot from the same voter was seen.
- id_err  out  1  sticky: a voter_id greater than 4 was seen.

Behaviour:
- Reset (synchronous, active-high) forces state IDLE and clears every output and internal register: vote, received mask, timer, decision, yes_count, result_valid, timed_out, dup_err, id_err, ballot_ready.
- Reset asserted mid-election abandons the election. No partial result is emitted.
- IDLE:
  - start=1: clear vote, received mask, timer, dup_err, id_err and timed_out; go to COLLECT next cycle.
  - start is ignored in every other state.
- COLLECT:
  - ballot_ready=1; a ballot is accepted when ballot_valid and ballot_ready are both 1.
  - Legal, first ballot for voter_id: write vote[voter_id] = ballot and set received[voter_id].
  - Repeat ballot for a voter: discarded (first vote stands); set dup_err.
  - voter_id > 4: discarded; set id_err.
  - Timer increments every COLLECT cycle.
  - Once received == 5'b11111 (including on the accepting edge): go to EVAL next cycle.
  - Otherwise, when the timer reaches TIMEOUT-1: set timed_out and go to EVAL. Unreceived bits stay 0.
  - Completion and timeout on the same cycle: completion wins, timed_out=0.
- EVAL (exactly one cycle):
  - ballot_ready=0; vote is stable, so majority_in has settled.
  - Register decision <= majority_in and yes_count <= popcount(vote); go to DONE.
- DONE:
  - result_valid=1; all outputs held.
  - result_ack=1: result_valid falls next cycle; go to IDLE.
  - vote keeps its value until the next start.
- Latency: last accepted ballot -> result_valid high is 2 cycles. start -> ballot_ready high is 1 cycle.
- Error flags are sticky until the next start or reset.

Decomposition:
- Shared package/include: state encodings (IDLE=0, COLLECT=1, EVAL=2, DONE=3), NUM_VOTERS=5, ID width 3.
- One natural sub-module, vote_timer: a loadable/clearable counter with a terminal-count flag, parameterised by TIMEOUT.
- The popcount stays inline.
- The majority voter itself is instantiated beside the collector at the parent level, vote -> voter -> majority_in. It is not inside this block.

Test Plan:
- Full yes: reset, start, ballots IDs 0..4 with values 1,1,0,1,0 -> vote=5'b01011, decision=1, yes_count=3, result_valid high 2 cycles after the 5th ballot, timed_out=0.
- Minority: ballots 1,0,0,0,1 (IDs 0..4), out of order (4,2,0,3,1) -> vote=5'b10001, decision=0, yes_count=2.
- Duplicate: ID 2 sends 1 then 0 -> vote[2]=1, dup_err=1; election still completes normally.
- Bad ID: voter_id=6 -> ignored, id_err=1, vote unchanged.
- Timeout with TIMEOUT=8: only IDs 0,1,2 vote 1 -> after 8 COLLECT cycles timed_out=1, vote=5'b00111, decision=1, yes_count=3.
- Reset during COLLECT after 3 ballots -> next cycle IDLE, all outputs 0. A new start begins with vote=0; result_ack without a pending result has no effect.

Source files
------------

// File: rtl/vote_collector_pkg.sv
// Shared encodings and widths for the ballot collector in front of the 5-input majority voter.
package vote_collector_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_EVAL    = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam int NUM_VOTERS = 5;
   localparam int ID_W       = 3;
   localparam int CNT_W      = 16;

endpackage

// File: rtl/vote_collector_timer.sv
// Collection-window counter: clears on a new election, counts while enabled and flags the last allowed cycle.
module vote_timer #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic tc
);
   import vote_collector_pkg::*;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Holds at the terminal value rather than wrapping, so tc can never re-fire spuriously.
   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (en && (count_q != LAST)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign tc = (count_q == LAST);

endmodule

// File: rtl/vote_collector.sv
// Gathers one ballot per voter, drives the external majority voter with the vote word and latches its verdict.
module vote_collector #(
   parameter int TIMEOUT    = 64,
   parameter int NUM_VOTERS = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  ballot_valid,
   output logic                  ballot_ready,
   input  logic [2:0]            voter_id,
   input  logic                  ballot,
   output logic [NUM_VOTERS-1:0] vote,
   input  logic                  majority_in,
   output logic                  result_valid,
   input  logic                  result_ack,
   output logic                  decision,
   output logic [2:0]            yes_count,
   output logic                  timed_out,
   output logic                  dup_err,
   output logic                  id_err
);
   import vote_collector_pkg::*;

   if (NUM_VOTERS != 5) begin : g_bad_num_voters
      $error("vote_collector: NUM_VOTERS must be 5");
   end
   if ((TIMEOUT < 1) || (TIMEOUT > 65535)) begin : g_bad_timeout
      $error("vote_collector: TIMEOUT must be in 1..65535");
   end

   state_t                state_q, state_d;
   logic [NUM_VOTERS-1:0] vote_q, vote_d;
   logic [NUM_VOTERS-1:0] rcv_q, rcv_d;
   logic                  ready_q, ready_d;
   logic                  valid_q, valid_d;
   logic                  dec_q, dec_d;
   logic [2:0]            yes_q, yes_d;
   logic                  to_q, to_d;
   logic                  dup_q, dup_d;
   logic                  id_q, id_d;
   logic [2:0]            ones;
   logic                  timer_clr;
   logic                  timer_en;
   logic                  timer_tc;

   vote_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .clr   (timer_clr),
      .en    (timer_en),
      .tc    (timer_tc)
   );

   always_comb begin
      ones = '0;
      for (int i = 0; i < NUM_VOTERS; i++) begin
         ones = ones + 3'(vote_q[i]);
      end
   end

   always_comb begin
      state_d   = state_q;
      vote_d    = vote_q;
      rcv_d     = rcv_q;
      ready_d   = ready_q;
      valid_d   = valid_q;
      dec_d     = dec_q;
      yes_d     = yes_q;
      to_d      = to_q;
      dup_d     = dup_q;
      id_d      = id_q;
      timer_clr = 1'b0;
      timer_en  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               vote_d    = '0;
               rcv_d     = '0;
               to_d      = 1'b0;
               dup_d     = 1'b0;
               id_d      = 1'b0;
               timer_clr = 1'b1;
               ready_d   = 1'b1;
               state_d   = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            timer_en = 1'b1;
            if (ballot_valid && ready_q) begin
               if (voter_id >= 3'(NUM_VOTERS)) begin
                  id_d = 1'b1;
               end else begin
                  for (int i = 0; i < NUM_VOTERS; i++) begin
                     if (voter_id == 3'(i)) begin
                        if (rcv_q[i]) begin
                           dup_d = 1'b1;
                        end else begin
                           vote_d[i] = ballot;
                           rcv_d[i]  = 1'b1;
                        end
                     end
                  end
               end
            end
            // A ballot that completes the roll on the timeout cycle still counts as a full election.
            if (&rcv_d) begin
               ready_d = 1'b0;
               state_d = ST_EVAL;
            end else if (timer_tc) begin
               to_d    = 1'b1;
               ready_d = 1'b0;
               state_d = ST_EVAL;
            end
         end
         ST_EVAL: begin
            dec_d   = majority_in;
            yes_d   = ones;
            valid_d = 1'b1;
            state_d = ST_DONE;
         end
         ST_DONE: begin
            if (result_ack) begin
               valid_d = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         vote_q  <= '0;
         rcv_q   <= '0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         dec_q   <= 1'b0;
         yes_q   <= '0;
         to_q    <= 1'b0;
         dup_q   <= 1'b0;
         id_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         vote_q  <= vote_d;
         rcv_q   <= rcv_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         dec_q   <= dec_d;
         yes_q   <= yes_d;
         to_q    <= to_d;
         dup_q   <= dup_d;
         id_q    <= id_d;
      end
   end

   assign ballot_ready = ready_q;
   assign vote         = vote_q;
   assign result_valid = valid_q;
   assign decision     = dec_q;
   assign yes_count    = yes_q;
   assign timed_out    = to_q;
   assign dup_err      = dup_q;
   assign id_err       = id_q;

endmodule
